sequential_divider: RTL and testbench
=====================================

# sequential_divider

Multi-cycle signed/unsigned integer divider for the simple ALU, the inverse of the multiplier. It accepts a WIDTH-bit dividend and divisor and produces a WIDTH-bit quotient and remainder. It uses restoring division on operand magnitudes, one quotient bit per clock, followed by a sign-fix cycle. Its status flags (negative, zero, overflow, cout) match the multiplier's, so the ALU flag mux treats both units the same way.

## Interface
- WIDTH, 4, operand, quotient and remainder width (≥2)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  request; sampled only in IDLE
- x  input  WIDTH  dividend
- y  input  WIDTH  divisor
- signed_unsigned  input  1  1 = two's-complement operands, 0 = unsigned
- busy  output  1  high while an operation is in flight (RUN or FIX)
- done  output  1  one-cycle pulse: q/rem/flags valid
- q  output  WIDTH  quotient
- rem  output  WIDTH  remainder
- negative  output  1  signed_unsigned & q[WIDTH-1]
- zero  output  1  q == 0
- overflow  output  1  divide-by-zero, or signed MIN / -1
- cout  output  1  always 0

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE, iteration counter 0, and all outputs 0.
- IDLE, start=1: latch x, y and signed_unsigned.
  - Compute magnitudes |x| and |y| when signed_unsigned=1; use raw values otherwise.
  - Record the quotient sign (sx^sy) and the remainder sign (sx).
  - Clear the WIDTH+1-bit partial remainder, load counter = WIDTH, go to RUN.
- RUN, each cycle: shift {partial remainder, dividend} left by 1 and trial-subtract the divisor magnitude.
  - Non-negative result: keep the difference and shift 1 into the quotient.
  - Negative result: restore and shift 0.
  - Decrement the counter; at 0 go to FIX.
- FIX: apply signs and write q, rem and the flags to their output registers. Pulse done, go to IDLE.
- Signed results: the quotient truncates toward zero; the remainder takes the dividend's sign. x = q*y + rem holds whenever overflow=0.
- Divide-by-zero (latched y==0): q = all ones, rem = x, overflow=1. This case still runs the full RUN/FIX sequence, so latency is constant.
- Signed MIN / -1: q = MIN (wraps), rem = 0, overflow=1.
- Outputs q, rem and the flags hold their values until the next FIX.
- start is ignored while busy=1. Operands changing during RUN have no effect.
- start=1 in the cycle done=1 is accepted, because the block is already in IDLE.

## Timing
- Edge E0 samples start: busy rises after E0.
- Edges E1..E_WIDTH perform the iterations.
- Edge E_WIDTH+1 (FIX) registers the results. After it, done=1 for exactly one cycle and busy=0.
- Total latency is WIDTH+1 edges from the accepting edge to valid outputs (5 for WIDTH=4). Throughput is one operation per WIDTH+2 cycles.
- reset=1 at any edge aborts the operation:
  - The next cycle is IDLE with busy=0, done=0, and all outputs 0.
  - No done pulse is issued for the aborted operation.
- reset has priority over start in the same cycle.
- done and busy are never both high.

## Test plan
- WIDTH=4, unsigned, x=13, y=3, start one cycle -> after 5 edges done=1, q=4, rem=1, zero=0, negative=0, overflow=0; done low the following cycle.
- Signed, x=4'b1001 (-7), y=2 -> q=4'b1101 (-3), rem=4'b1111 (-1), negative=1; unsigned with the same bits (9/2) -> q=4, rem=1, negative=0.
- Divide-by-zero: x=9, y=0, either mode -> q=4'hF, rem=9, overflow=1, same 5-edge latency; signed x=4'h8 (-8), y=4'hF (-1) -> q=4'h8, rem=0, overflow=1, negative=1.
- x=2, y=5 unsigned -> q=0, rem=2, zero=1. Back-to-back: start re-asserted in the done cycle with 15/15 -> q=1, rem=0, five edges later.
- start pulsed with different operands during RUN -> ignored, first result unchanged. reset asserted on the 3rd RUN edge -> busy=0, q=rem=0, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle signed/unsigned restoring divider.
// Ports: clk, reset (sync, active-high), start, x (dividend), y (divisor), signed_unsigned;
// busy while RUN/FIX, done one-cycle pulse, q, rem, negative, zero, overflow, cout (always 0).
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_unsigned,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] pr, dd, ym, xl, xm, ymn, qv, rv;
  logic [WIDTH:0] sh;
  logic ge, qs, rs, su, dz, ov;
  // A restored partial remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra bit.
  assign sh = {pr, dd[WIDTH-1]};
  assign ge = sh >= {1'b0, ym};
  assign xm = (signed_unsigned & x[WIDTH-1]) ? -x : x;
  assign ymn = (signed_unsigned & y[WIDTH-1]) ? -y : y;
  assign qv = dz ? '1 : qs ? -dd : dd;
  assign rv = dz ? xl : rs ? -pr : pr;
  assign busy = state != IDLE;
  assign cout = 1'b0;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN)  ? ((cnt == CW'(1)) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      pr <= '0;
      dd <= '0;
      ym <= '0;
      xl <= '0;
      qs <= 1'b0;
      rs <= 1'b0;
      su <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      done <= 1'b0;
      q <= '0;
      rem <= '0;
      negative <= 1'b0;
      zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE && start) begin
        xl <= x;
        ym <= ymn;
        dd <= xm;
        pr <= '0;
        cnt <= CW'(WIDTH);
        qs <= signed_unsigned & (x[WIDTH-1] ^ y[WIDTH-1]);
        rs <= signed_unsigned & x[WIDTH-1];
        su <= signed_unsigned;
        dz <= y == '0;
        ov <= (y == '0) | (signed_unsigned & (x == MIN) & (y == '1));
      end else if (state == RUN) begin
        pr <= ge ? WIDTH'(sh - {1'b0, ym}) : sh[WIDTH-1:0];
        dd <= {dd[WIDTH-2:0], ge};
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        q <= qv;
        rem <= rv;
        negative <= su & qv[WIDTH-1];
        zero <= qv == '0;
        overflow <= ov;
      end
    end
  end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed and random checks of sequential_divider against an arithmetic model.
module tb_sequential_divider;
  localparam int W = 4;
  logic clk = 0, reset = 1, start = 0, signed_unsigned = 0;
  logic [W-1:0] x = 0, y = 0, q, rem;
  logic busy, done, negative, zero, overflow, cout;
  int tests = 0, fails = 0;
  sequential_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .signed_unsigned(signed_unsigned), .busy(busy), .done(done), .q(q), .rem(rem),
    .negative(negative), .zero(zero), .overflow(overflow), .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] eq, output logic [W-1:0] er, output bit eo);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      eq = '1; er = a; eo = 1;
    end else if (s && sa == -(1 << (W - 1)) && sb == -1) begin
      eq = a; er = 0; eo = 1;
    end else if (s) begin
      eq = W'(sa / sb); er = W'(sa % sb); eo = 0;
    end else begin
      eq = a / b; er = a % b; eo = 0;
    end
  endfunction
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit glitch);
    logic [W-1:0] eq, er;
    bit eo;
    model(a, b, s, eq, er, eo);
    x = a; y = b; signed_unsigned = s; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i <= W; i++) begin
      chk("busy_inflight", busy, 1);
      chk("done_early", done, 0);
      if (glitch && i == 2) begin
        start = 1; x = ~a; y = b + 1; signed_unsigned = ~s;
      end
      if (glitch && i == 3) start = 0;
      @(posedge clk); #1;
    end
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("q", q, eq);
    chk("rem", rem, er);
    chk("overflow", overflow, eo);
    chk("negative", negative, s & eq[W-1]);
    chk("zero", zero, eq == 0);
    chk("cout", cout, 0);
  endtask
  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_pulse_len", done, 0);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_rem", rem, 0);
    chk("rst_flags", {negative, zero, overflow, cout}, 0);
    op(4'd13, 4'd3, 0, 0); idle_cycle();
    op(4'b1001, 4'd2, 1, 0); idle_cycle();
    op(4'b1001, 4'd2, 0, 0); idle_cycle();
    op(4'd9, 4'd0, 0, 0); idle_cycle();
    op(4'd9, 4'd0, 1, 0); idle_cycle();
    op(4'h8, 4'hF, 1, 0); idle_cycle();
    op(4'd2, 4'd5, 0, 0);
    op(4'd15, 4'd15, 0, 0); idle_cycle();
    op(4'd14, 4'd4, 0, 1); idle_cycle();
    x = 4'd13; y = 4'd3; signed_unsigned = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", q, 0);
    chk("abort_rem", rem, 0);
    chk("abort_flags", {negative, zero, overflow}, 0);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    op(4'd7, 4'd2, 1, 0); idle_cycle();
    for (int n = 0; n < 300; n++) begin
      op(W'($urandom_range(15)), W'($urandom_range(15)), 1'($urandom_range(1)),
         $urandom_range(7) == 0);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
